dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data memory (256 x 16) between the processor control unit (CPU port) and the external program/debug loader (DBG port). It sits between the control unit's D_addr/D_wr path and the data memory. It serializes accesses through a three-state sequencer with a request/grant/done handshake, and routes read data back to the winner.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_starve_counter.sv | 33 +++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: sequencer states, owner encoding
// and a state-name helper for messages.
package ArbDefs;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } ArbState;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } ArbOwner;

  function automatic string arbstate_to_string(input ArbState s);
    case (s)
      ARB_IDLE:   return "ARB_IDLE";
      ARB_ACCESS: return "ARB_ACCESS";
      ARB_DONE:   return "ARB_DONE";
      default:    return "ARB_UNKNOWN";
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter for a losing DBG request; sat flags that DBG has
// waited MAX_WAIT consecutive cycles.
module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_r;

  // Count losing cycles, clearing on grant or withdrawn request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != MAX_CNT)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign sat = (count_r == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DBG arbiter for the single-port data memory (IDLE/ACCESS/DONE sequencer).
// Optional DBG starvation guard is compiled in with DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
  import ArbDefs::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cpu_req,
  input  logic              Cpu_wr,
  input  logic [ADDR_W-1:0] Cpu_addr,
  input  logic [DATA_W-1:0] Cpu_wdata,
  output logic              Cpu_gnt,
  output logic              Cpu_done,
  input  logic              Dbg_req,
  input  logic              Dbg_wr,
  input  logic [ADDR_W-1:0] Dbg_addr,
  input  logic [DATA_W-1:0] Dbg_wdata,
  output logic              Dbg_gnt,
  output logic              Dbg_done,
  output logic [DATA_W-1:0] Rd_data,
  output logic [ADDR_W-1:0] M_addr,
  output logic              M_wr,
  output logic [DATA_W-1:0] M_wdata,
  input  logic [DATA_W-1:0] M_rdata,
  output logic              Busy
);

  ArbState state_r, state_nx_s;
  ArbOwner owner_r, owner_nx_s, pick_s;
  logic    cpu_gnt_r, dbg_gnt_r, cpu_done_r, dbg_done_r, busy_r;
  logic    any_req_s, starve_s;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (Dbg_req & ~dbg_gnt_r),
    .clr   (~Dbg_req | dbg_gnt_r),
    .sat   (starve_s)
  );
`else
  logic unused_max_wait_s;
  assign unused_max_wait_s = (MAX_WAIT != 0);
  assign starve_s = 1'b0;
`endif

  // Arbitration: CPU wins ties unless DBG has saturated its wait counter.
  always_comb begin
    any_req_s = Cpu_req | Dbg_req;
    if (Dbg_req && (!Cpu_req || starve_s)) begin
      pick_s = OWN_DBG;
    end else begin
      pick_s = OWN_CPU;
    end
  end

  // Sequencer next state; DONE re-arbitrates for back-to-back accesses.
  always_comb begin
    state_nx_s = state_r;
    owner_nx_s = owner_r;
    case (state_r)
      ARB_IDLE, ARB_DONE: begin
        if (any_req_s) begin
          state_nx_s = ARB_ACCESS;
          owner_nx_s = pick_s;
        end else begin
          state_nx_s = ARB_IDLE;
        end
      end
      ARB_ACCESS: state_nx_s = ARB_DONE;
      default:    state_nx_s = ARB_IDLE;
    endcase
  end

  // State, owner and handshake flops decoded from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ARB_IDLE;
      owner_r    <= OWN_CPU;
      cpu_gnt_r  <= 1'b0;
      dbg_gnt_r  <= 1'b0;
      cpu_done_r <= 1'b0;
      dbg_done_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      owner_r    <= owner_nx_s;
      cpu_gnt_r  <= (state_nx_s != ARB_IDLE) && (owner_nx_s == OWN_CPU);
      dbg_gnt_r  <= (state_nx_s != ARB_IDLE) && (owner_nx_s == OWN_DBG);
      cpu_done_r <= (state_nx_s == ARB_DONE) && (owner_nx_s == OWN_CPU);
      dbg_done_r <= (state_nx_s == ARB_DONE) && (owner_nx_s == OWN_DBG);
      busy_r     <= (state_nx_s != ARB_IDLE);
    end
  end

  // Memory-side mux and read-data return; write is killed by a reset cycle.
  always_comb begin
    M_addr  = '0;
    M_wdata = '0;
    M_wr    = 1'b0;
    Rd_data = '0;
    case (state_r)
      ARB_ACCESS: begin
        if (owner_r == OWN_DBG) begin
          M_addr  = Dbg_addr;
          M_wdata = Dbg_wdata;
          M_wr    = Dbg_wr & ~Reset;
        end else begin
          M_addr  = Cpu_addr;
          M_wdata = Cpu_wdata;
          M_wr    = Cpu_wr & ~Reset;
        end
      end
      ARB_DONE: Rd_data = M_rdata;
      default:  Rd_data = '0;
    endcase
  end

  assign Cpu_gnt  = cpu_gnt_r;
  assign Dbg_gnt  = dbg_gnt_r;
  assign Cpu_done = cpu_done_r;
  assign Dbg_done = dbg_done_r;
  assign Busy     = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 256x16 memory and a
// per-port expected-response queue checked by an independent monitor.
module tb_dmem_arbiter;
  import ArbDefs::*;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Cpu_req, Cpu_wr, Dbg_req, Dbg_wr;
  logic [ADDR_W-1:0] Cpu_addr, Dbg_addr, M_addr;
  logic [DATA_W-1:0] Cpu_wdata, Dbg_wdata, Rd_data, M_wdata, M_rdata;
  logic              Cpu_gnt, Cpu_done, Dbg_gnt, Dbg_done, M_wr, Busy;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic        mem_init;
  exp_t        cpu_q[$];
  exp_t        dbg_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Reset(Reset),
    .Cpu_req(Cpu_req), .Cpu_wr(Cpu_wr), .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata),
    .Cpu_gnt(Cpu_gnt), .Cpu_done(Cpu_done),
    .Dbg_req(Dbg_req), .Dbg_wr(Dbg_wr), .Dbg_addr(Dbg_addr), .Dbg_wdata(Dbg_wdata),
    .Dbg_gnt(Dbg_gnt), .Dbg_done(Dbg_done),
    .Rd_data(Rd_data), .M_addr(M_addr), .M_wr(M_wr), .M_wdata(M_wdata),
    .M_rdata(M_rdata), .Busy(Busy)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 257) ^ 16'hA5A5;
  endfunction

  // Synchronous single-port memory: read data one cycle after address.
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (M_wr) begin
      mem[M_addr] <= M_wdata;
    end
    M_rdata <= mem[M_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: every done pulse pops the owner's queue and checks read data.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Cpu_gnt || Dbg_gnt) check("gnt_exclusive", {31'd0, Cpu_gnt & Dbg_gnt}, 32'd0);
      if (Cpu_done) begin
        if (cpu_q.size() == 0) check("cpu_done_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = cpu_q.pop_front();
          if (!mon_e.wr) check("cpu_rdata", {16'd0, Rd_data}, {16'd0, mon_e.data});
        end
      end
      if (Dbg_done) begin
        if (dbg_q.size() == 0) check("dbg_done_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = dbg_q.pop_front();
          if (!mon_e.wr) check("dbg_rdata", {16'd0, Rd_data}, {16'd0, mon_e.data});
        end
      end
    end
  end

  function automatic exp_t make_exp(input bit wr, input logic [7:0] addr, input logic [15:0] wd);
    exp_t e;
    e.wr   = wr;
    e.addr = addr;
    e.data = wr ? wd : ref_mem[addr];
    if (wr) ref_mem[addr] = wd;
    return e;
  endfunction

  // One handshake on a port; returns edges to first gnt and to done.
  task automatic access(input bit dbg, input bit wr, input logic [7:0] addr,
                        input logic [15:0] wd, output int lat, output int gnt_lat,
                        output int wr_cycles, output logic [7:0] wr_addr);
    lat = 0; gnt_lat = 0; wr_cycles = 0; wr_addr = 8'h00;
    if (dbg) begin
      dbg_q.push_back(make_exp(wr, addr, wd));
      Dbg_wr = wr; Dbg_addr = addr; Dbg_wdata = wd; Dbg_req = 1'b1;
    end else begin
      cpu_q.push_back(make_exp(wr, addr, wd));
      Cpu_wr = wr; Cpu_addr = addr; Cpu_wdata = wd; Cpu_req = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (gnt_lat == 0 && (dbg ? Dbg_gnt : Cpu_gnt)) gnt_lat = i;
      if (M_wr && (dbg ? Dbg_gnt : Cpu_gnt)) begin
        wr_cycles++;
        wr_addr = M_addr;
      end
      if (dbg ? Dbg_done : Cpu_done) begin
        lat = i;
        break;
      end
    end
    if (dbg) Dbg_req = 1'b0; else Cpu_req = 1'b0;
    if (lat == 0) check(dbg ? "dbg_timeout" : "cpu_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  int          lat_c, gl_c, wc_c, lat_d, gl_d, wc_d, first_gnt;
  logic [7:0]  wa_c, wa_d;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; mem_init = 1'b1;
    Cpu_req = 1'b0; Cpu_wr = 1'b0; Cpu_addr = 8'h00; Cpu_wdata = 16'h0000;
    Dbg_req = 1'b0; Dbg_wr = 1'b0; Dbg_addr = 8'h00; Dbg_wdata = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    tick(3);
    mem_init = 1'b0; Reset = 1'b0;

    // Reset state after five idle cycles.
    tick(5);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_gnt", {30'd0, Cpu_gnt, Dbg_gnt}, 32'd0);
    check("rst_done", {30'd0, Cpu_done, Dbg_done}, 32'd0);
    check("rst_mwr", {31'd0, M_wr}, 32'd0);
    check("rst_maddr_wdata", {8'd0, M_addr, M_wdata}, 32'd0);
    check("rst_rdata", {16'd0, Rd_data}, 32'd0);
    checks++;
    if (dut.state_r != ARB_IDLE) begin
      errors++;
      $display("FAIL rst_state: got %s expected ARB_IDLE", arbstate_to_string(dut.state_r));
    end

    // CPU write then read back.
    access(1'b0, 1'b1, 8'h12, 16'hBEEF, lat_c, gl_c, wc_c, wa_c);
    check("wr_mwr_cycles", wc_c, 32'd1);
    check("wr_maddr", {24'd0, wa_c}, 32'h12);
    check("wr_latency", lat_c, 32'd2);
    tick(1);
    access(1'b0, 1'b0, 8'h12, 16'h0000, lat_c, gl_c, wc_c, wa_c);
    check("rd_latency", lat_c, 32'd2);
    check("rd_gnt_latency", gl_c, 32'd1);
    tick(2);

    // Simultaneous requests: CPU first, DBG back-to-back.
    fork
      access(1'b0, 1'b0, 8'h01, 16'h0000, lat_c, gl_c, wc_c, wa_c);
      access(1'b1, 1'b0, 8'h02, 16'h0000, lat_d, gl_d, wc_d, wa_d);
    join
    check("tie_cpu_done_lat", lat_c, 32'd2);
    check("tie_dbg_gnt_lat", gl_d, 32'd3);
    check("tie_dbg_done_lat", lat_d, 32'd4);
    tick(2);

    // Continuous CPU traffic against a held DBG request.
    Cpu_wr = 1'b0; Cpu_addr = 8'h05; Dbg_wr = 1'b0; Dbg_addr = 8'h85;
    first_gnt = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    repeat (2) cpu_q.push_back(make_exp(1'b0, 8'h05, 16'h0000));
    dbg_q.push_back(make_exp(1'b0, 8'h85, 16'h0000));
    Cpu_req = 1'b1; Dbg_req = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge Clk); #1;
      if (first_gnt == 0 && Dbg_gnt) first_gnt = i;
      if (Dbg_done) break;
    end
    Cpu_req = 1'b0; Dbg_req = 1'b0;
    check("starve_dbg_gnt_edge", first_gnt, 32'd5);
`else
    repeat (25) cpu_q.push_back(make_exp(1'b0, 8'h05, 16'h0000));
    Cpu_req = 1'b1; Dbg_req = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge Clk); #1;
      if (first_gnt == 0 && Dbg_gnt) first_gnt = i;
    end
    Cpu_req = 1'b0; Dbg_req = 1'b0;
    check("strict_dbg_never_gnt", first_gnt, 32'd0);
`endif
    tick(2);
    check("starve_idle_after", {31'd0, Busy}, 32'd0);

    // Reset during a DBG write access aborts it.
    access(1'b0, 1'b1, 8'h30, 16'h1234, lat_c, gl_c, wc_c, wa_c);
    tick(1);
    Dbg_wr = 1'b1; Dbg_addr = 8'h30; Dbg_wdata = 16'h5555; Dbg_req = 1'b1;
    tick(1);
    check("abort_pre_mwr", {31'd0, M_wr}, 32'd1);
    Reset = 1'b1;
    #1;
    check("abort_mwr_gated", {31'd0, M_wr}, 32'd0);
    @(posedge Clk); #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_no_done", {31'd0, Dbg_done}, 32'd0);
    Dbg_req = 1'b0; Dbg_wr = 1'b0; Reset = 1'b0;
    tick(1);
    access(1'b0, 1'b0, 8'h30, 16'h0000, lat_c, gl_c, wc_c, wa_c);
    tick(1);

    // Request withdrawn mid-access still completes.
    cpu_q.push_back(make_exp(1'b0, 8'h12, 16'h0000));
    Cpu_wr = 1'b0; Cpu_addr = 8'h12; Cpu_req = 1'b1;
    tick(1);
    check("drop_gnt", {31'd0, Cpu_gnt}, 32'd1);
    Cpu_req = 1'b0;
    tick(1);
    check("drop_done", {31'd0, Cpu_done}, 32'd1);
    tick(1);
    check("drop_idle", {31'd0, Busy}, 32'd0);
    tick(1);
    check("drop_no_regrant", {30'd0, Busy, Cpu_gnt}, 32'd0);

    // Random concurrent traffic on disjoint address halves.
    fork
      begin
        int l, g, w;
        logic [7:0] a;
        for (int n = 0; n < 40; n++) begin
          access(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)),
                 16'($urandom), l, g, w, a);
          tick($urandom_range(0, 3));
        end
      end
      begin
        int l, g, w;
        logic [7:0] a;
        for (int n = 0; n < 40; n++) begin
          access(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)),
                 16'($urandom), l, g, w, a);
          tick($urandom_range(0, 3));
        end
      end
    join
    tick(3);
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    check("dbg_q_drained", dbg_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
